// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator controller: FSM states,
// operator key codes and BCD sizing.
package calc_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_OP_WAIT,
        ST_ENTER_B,
        ST_EXEC,
        ST_RESULT,
        ST_ERROR
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_IGN = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD operand entry register: shifts digits in from the right until DIGITS
// digits have been entered, with clear, single-digit restart and parallel load.
module bcd_entry_reg #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  load,
    input  logic                  shift,
    input  logic [3:0]            digit,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic [4*DIGITS-1:0]   value_nxt
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [W-1:0]  val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clr) begin
            val_d = '0;
            cnt_d = '0;
        end else if (start) begin
            val_d = {{(W-4){1'b0}}, digit};
            cnt_d = CW'(1);
        end else if (load) begin
            // A loaded result counts as a full operand; no more digits go in.
            val_d = load_val;
            cnt_d = FULL;
        end else if (shift && cnt_q != FULL) begin
            val_d = {val_q[W-5:0], digit};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign value     = val_q;
    assign value_nxt = val_d;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator controller: assembles BCD operands from key events,
// issues one external BCD ALU operation per '=' or chained operator, drives display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic                  is_num,
    input  logic                  is_op,
    input  logic                  is_eq,
    input  logic [3:0]            num_val,
    input  logic [1:0]            op_val,
    output logic                  alu_start,
    output logic [4*DIGITS-1:0]   alu_a,
    output logic [4*DIGITS-1:0]   alu_b,
    output logic                  alu_sub,
    input  logic                  alu_done,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_neg,
    input  logic                  alu_ovf,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_neg,
    output logic                  disp_err,
    output logic                  busy
);

    localparam int W  = BCD_W * DIGITS;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic          op_sub_q, op_sub_d;
    logic          pend_sub_q, pend_sub_d;
    logic          chain_q, chain_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          alu_start_q, alu_start_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic          alu_sub_q, alu_sub_d;
    logic [W-1:0]  disp_bcd_q, disp_bcd_d;
    logic          disp_neg_q, disp_neg_d;
    logic          disp_err_q, disp_err_d;
    logic          busy_q, busy_d;

    logic          a_clr, a_start, a_load, a_shift;
    logic          b_clr, b_start, b_shift;
    logic [W-1:0]  a_val, a_nxt, b_val, b_nxt, a_load_val;

    logic k_eq, k_op, k_num, k_clr, k_arith, k_sub;

    // Priority eq > op > num; invalid digits and the spare op code act as no key.
    assign k_eq    = key_valid & is_eq;
    assign k_op    = key_valid & ~is_eq & is_op;
    assign k_num   = key_valid & ~is_eq & ~is_op & is_num & is_bcd_digit(num_val);
    assign k_clr   = k_op & (op_val == OP_CLR);
    assign k_arith = k_op & ((op_val == OP_ADD) | (op_val == OP_SUB));
    assign k_sub   = (op_val == OP_SUB);

    // A is reloaded either from the ALU (chained op) or from the held result.
    assign a_load_val = (state_q == ST_EXEC) ? alu_result : disp_bcd_q;

    bcd_entry_reg #(.DIGITS(DIGITS)) u_entry_a (
        .clk(clk), .rst(rst), .clr(a_clr), .start(a_start), .load(a_load),
        .shift(a_shift), .digit(num_val), .load_val(a_load_val),
        .value(a_val), .value_nxt(a_nxt)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_entry_b (
        .clk(clk), .rst(rst), .clr(b_clr), .start(b_start), .load(1'b0),
        .shift(b_shift), .digit(num_val), .load_val('0),
        .value(b_val), .value_nxt(b_nxt)
    );

    always_comb begin
        state_d     = state_q;
        op_sub_d    = op_sub_q;
        pend_sub_d  = pend_sub_q;
        chain_d     = chain_q;
        timer_d     = '0;
        alu_start_d = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sub_d   = alu_sub_q;
        a_clr = 1'b0; a_start = 1'b0; a_load = 1'b0; a_shift = 1'b0;
        b_clr = 1'b0; b_start = 1'b0; b_shift = 1'b0;

        if (k_clr && state_q != ST_EXEC) begin
            state_d    = ST_ENTER_A;
            op_sub_d   = 1'b0;
            pend_sub_d = 1'b0;
            chain_d    = 1'b0;
            alu_a_d    = '0;
            alu_b_d    = '0;
            alu_sub_d  = 1'b0;
            a_clr      = 1'b1;
            b_clr      = 1'b1;
        end else begin
            unique case (state_q)
                ST_ENTER_A: begin
                    if (k_num) begin
                        a_shift = 1'b1;
                    end else if (k_arith) begin
                        op_sub_d = k_sub;
                        state_d  = ST_OP_WAIT;
                    end
                end
                ST_OP_WAIT: begin
                    if (k_num) begin
                        b_start = 1'b1;
                        state_d = ST_ENTER_B;
                    end else if (k_arith) begin
                        op_sub_d = k_sub;
                    end
                end
                ST_ENTER_B: begin
                    if (k_num) begin
                        b_shift = 1'b1;
                    end else if (k_eq || k_arith) begin
                        state_d     = ST_EXEC;
                        chain_d     = k_arith;
                        pend_sub_d  = k_sub;
                        alu_start_d = 1'b1;
                        alu_a_d     = a_val;
                        alu_b_d     = b_val;
                        alu_sub_d   = op_sub_q;
                    end
                end
                ST_EXEC: begin
                    if (alu_done) begin
                        if (alu_ovf) begin
                            state_d = ST_ERROR;
                        end else if (!chain_q || alu_neg) begin
                            // A negative intermediate cannot be an operand, so the chain stops here.
                            state_d = ST_RESULT;
                        end else begin
                            a_load   = 1'b1;
                            op_sub_d = pend_sub_q;
                            state_d  = ST_OP_WAIT;
                        end
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_RESULT: begin
                    if (k_num) begin
                        a_start = 1'b1;
                        b_clr   = 1'b1;
                        state_d = ST_ENTER_A;
                    end else if (k_arith && !disp_neg_q) begin
                        a_load   = 1'b1;
                        op_sub_d = k_sub;
                        state_d  = ST_OP_WAIT;
                    end else if (k_eq && !disp_neg_q) begin
                        a_load      = 1'b1;
                        state_d     = ST_EXEC;
                        chain_d     = 1'b0;
                        alu_start_d = 1'b1;
                        alu_a_d     = disp_bcd_q;
                        alu_b_d     = b_val;
                        alu_sub_d   = op_sub_q;
                    end
                end
                ST_ERROR: ;
                default: state_d = ST_ERROR;
            endcase
        end
    end

    // Display tracks whichever value the next state presents.
    always_comb begin
        disp_bcd_d = disp_bcd_q;
        disp_neg_d = 1'b0;
        unique case (state_d)
            ST_ENTER_A, ST_OP_WAIT: disp_bcd_d = a_nxt;
            ST_ENTER_B:             disp_bcd_d = b_nxt;
            ST_ERROR:               disp_bcd_d = '0;
            ST_RESULT: begin
                disp_bcd_d = (state_q == ST_EXEC) ? alu_result : disp_bcd_q;
                disp_neg_d = (state_q == ST_EXEC) ? alu_neg : disp_neg_q;
            end
            default: ;
        endcase
        disp_err_d = (state_d == ST_ERROR);
        busy_d     = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTER_A;
            op_sub_q    <= 1'b0;
            pend_sub_q  <= 1'b0;
            chain_q     <= 1'b0;
            timer_q     <= '0;
            alu_start_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sub_q   <= 1'b0;
            disp_bcd_q  <= '0;
            disp_neg_q  <= 1'b0;
            disp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_sub_q    <= op_sub_d;
            pend_sub_q  <= pend_sub_d;
            chain_q     <= chain_d;
            timer_q     <= timer_d;
            alu_start_q <= alu_start_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sub_q   <= alu_sub_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_neg_q  <= disp_neg_d;
            disp_err_q  <= disp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_start = alu_start_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sub   = alu_sub_q;
    assign disp_bcd  = disp_bcd_q;
    assign disp_neg  = disp_neg_q;
    assign disp_err  = disp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed calculator scenarios plus
// randomized key streams checked against a decimal calculator model.
module tb_calc_sequencer;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0, is_num = 1'b0, is_op = 1'b0, is_eq = 1'b0;
    logic [3:0]  num_val = '0;
    logic [1:0]  op_val = '0;
    logic        alu_start, alu_sub;
    logic [15:0] alu_a, alu_b;
    logic        alu_done = 1'b0, alu_neg = 1'b0, alu_ovf = 1'b0;
    logic [15:0] alu_result = '0;
    logic [15:0] disp_bcd;
    logic        disp_neg, disp_err, busy;

    calc_sequencer #(.DIGITS(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .is_num(is_num), .is_op(is_op),
        .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .alu_start(alu_start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_done(alu_done),
        .alu_result(alu_result), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
        .disp_bcd(disp_bcd), .disp_neg(disp_neg), .disp_err(disp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int cyc = 0, start_cnt = 0;
    logic [15:0] cap_a, cap_b;
    logic        cap_sub, cap_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    // ---------------- decimal reference model ----------------
    localparam int MA = 0, MOPW = 1, MB = 2, MEX = 3, MRES = 4, MERR = 5;
    int m_mode, ma, na, mb, nb, mop, mpend, mchain, mres, mneg;
    int ra, rb, rsub;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_mode = MA; ma = 0; na = 0; mb = 0; nb = 0; mop = 0; mpend = 0;
        mchain = 0; mres = 0; mneg = 0;
    endfunction

    function automatic void model_key(input bit e, input bit o, input bit n,
                                      input int nv, input int ov);
        bit eq, op, num, clr, ar;
        eq = e; op = !e && o; num = !e && !o && n && nv <= 9;
        clr = op && ov == 3; ar = op && ov < 2;
        if (clr && m_mode != MEX) begin
            model_reset();
            return;
        end
        case (m_mode)
            MA:   if (num) begin if (na < 4) begin ma = ma * 10 + nv; na++; end end
                  else if (ar) begin mop = ov; m_mode = MOPW; end
            MOPW: if (num) begin mb = nv; nb = 1; m_mode = MB; end
                  else if (ar) mop = ov;
            MB:   if (num) begin if (nb < 4) begin mb = mb * 10 + nv; nb++; end end
                  else if (eq || ar) begin
                      m_mode = MEX; mchain = ar; mpend = ov; ra = ma; rb = mb; rsub = mop;
                  end
            MRES: if (num) begin ma = nv; na = 1; mb = 0; nb = 0; mneg = 0; m_mode = MA; end
                  else if (ar && !mneg) begin ma = mres; na = 4; mop = ov; m_mode = MOPW; end
                  else if (eq && !mneg) begin
                      ma = mres; na = 4; m_mode = MEX; mchain = 0; ra = mres; rb = mb; rsub = mop;
                  end
            default: ;
        endcase
    endfunction

    function automatic void model_done(input int v);
        int mag;
        mag = (v < 0) ? -v : v;
        if (mag > 9999) begin m_mode = MERR; mneg = 0; end
        else if (!mchain || v < 0) begin m_mode = MRES; mres = mag; mneg = (v < 0); end
        else begin ma = mag; na = 4; mop = mpend; m_mode = MOPW; mneg = 0; end
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic press(input bit e, input bit o, input bit n,
                         input logic [3:0] nv, input logic [1:0] ov);
        @(negedge clk);
        key_valid = 1'b1; is_eq = e; is_op = o; is_num = n; num_val = nv; op_val = ov;
        @(negedge clk);
        key_valid = 1'b0; is_eq = 1'b0; is_op = 1'b0; is_num = 1'b0; num_val = '0; op_val = '0;
    endtask

    task automatic dig(input int d);
        press(0, 0, 1, 4'(d), 2'b00);
    endtask

    task automatic opk(input logic [1:0] ov);
        press(0, 1, 0, 4'd0, ov);
    endtask

    task automatic eqk();
        press(1, 0, 0, 4'd0, 2'b00);
    endtask

    // Waits (bounded) for alu_start, captures the request, then answers after delay cycles.
    task automatic serve(input int delay, input logic [15:0] res, input bit neg,
                         input bit ovf, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (alu_start === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) return;
        cap_a = alu_a; cap_b = alu_b; cap_sub = alu_sub; cap_busy = busy;
        repeat (delay) @(negedge clk);
        alu_done = 1'b1; alu_result = res; alu_neg = neg; alu_ovf = ovf;
        @(negedge clk);
        alu_done = 1'b0; alu_result = '0; alu_neg = 1'b0; alu_ovf = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_start, alu_sub, busy, disp_neg, disp_err} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got=%b exp=00000", {alu_start, alu_sub, busy, disp_neg, disp_err});
        end
        checks++;
        if ({alu_a, alu_b, disp_bcd} !== 48'h0) begin
            fails++; $display("FAIL reset_buses got=%h exp=0", {alu_a, alu_b, disp_bcd});
        end
    endtask

    task automatic test_add();
        bit seen; int s0;
        dig(1); dig(2);
        checks++;
        if (disp_bcd !== 16'h0012) begin fails++; $display("FAIL add_entry_a got=%h exp=0012", disp_bcd); end
        opk(2'b00); dig(3); dig(4);
        checks++;
        if (disp_bcd !== 16'h0034) begin fails++; $display("FAIL add_entry_b got=%h exp=0034", disp_bcd); end
        s0 = start_cnt;
        eqk();
        serve(1, 16'h0046, 1'b0, 1'b0, seen);
        checks++;
        if (!seen || cap_a !== 16'h0012 || cap_b !== 16'h0034 || cap_sub !== 1'b0 || cap_busy !== 1'b1) begin
            fails++; $display("FAIL add_request seen=%0d a=%h b=%h sub=%b busy=%b exp a=0012 b=0034 sub=0 busy=1",
                              seen, cap_a, cap_b, cap_sub, cap_busy);
        end
        checks++;
        if (disp_bcd !== 16'h0046 || disp_neg !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL add_result got=%h neg=%b busy=%b exp=0046 neg=0 busy=0", disp_bcd, disp_neg, busy);
        end
        checks++;
        if (start_cnt - s0 != 1) begin fails++; $display("FAIL add_start_count got=%0d exp=1", start_cnt - s0); end
    endtask

    task automatic test_neg();
        bit seen; int s0;
        dig(5); opk(2'b01); dig(9); eqk();
        serve(0, 16'h0004, 1'b1, 1'b0, seen);
        checks++;
        if (!seen || cap_a !== 16'h0005 || cap_b !== 16'h0009 || cap_sub !== 1'b1) begin
            fails++; $display("FAIL neg_request seen=%0d a=%h b=%h sub=%b exp a=0005 b=0009 sub=1", seen, cap_a, cap_b, cap_sub);
        end
        checks++;
        if (disp_bcd !== 16'h0004 || disp_neg !== 1'b1) begin
            fails++; $display("FAIL neg_result got=%h neg=%b exp=0004 neg=1", disp_bcd, disp_neg);
        end
        s0 = start_cnt;
        opk(2'b00); eqk();
        repeat (3) @(negedge clk);
        checks++;
        if (disp_bcd !== 16'h0004 || disp_neg !== 1'b1 || busy !== 1'b0 || start_cnt != s0) begin
            fails++; $display("FAIL neg_keys_ignored got=%h neg=%b busy=%b starts=%0d exp=0004 neg=1 busy=0 starts=0",
                              disp_bcd, disp_neg, busy, start_cnt - s0);
        end
    endtask

    task automatic test_overflow();
        bit seen;
        opk(2'b11);
        for (int d = 1; d <= 5; d++) dig(d);
        checks++;
        if (disp_bcd !== 16'h1234) begin fails++; $display("FAIL ovf_digit_limit got=%h exp=1234", disp_bcd); end
        opk(2'b00); dig(1); eqk();
        serve(2, 16'h1235, 1'b0, 1'b1, seen);
        checks++;
        if (!seen || disp_err !== 1'b1 || disp_bcd !== 16'h0000) begin
            fails++; $display("FAIL ovf_error seen=%0d err=%b disp=%h exp err=1 disp=0000", seen, disp_err, disp_bcd);
        end
        dig(3); eqk();
        checks++;
        if (disp_err !== 1'b1 || disp_bcd !== 16'h0000 || busy !== 1'b0) begin
            fails++; $display("FAIL ovf_sticky err=%b disp=%h busy=%b exp err=1 disp=0000 busy=0", disp_err, disp_bcd, busy);
        end
        opk(2'b11);
        checks++;
        if ({disp_err, disp_neg, busy, alu_sub, alu_start} !== 5'b0 || {alu_a, alu_b, disp_bcd} !== 48'h0) begin
            fails++; $display("FAIL ovf_clear flags=%b buses=%h exp all zero",
                              {disp_err, disp_neg, busy, alu_sub, alu_start}, {alu_a, alu_b, disp_bcd});
        end
        dig(8);
        checks++;
        if (disp_bcd !== 16'h0008) begin fails++; $display("FAIL ovf_clear_entry got=%h exp=0008", disp_bcd); end
    endtask

    task automatic test_chain();
        bit seen;
        opk(2'b11);
        dig(7); opk(2'b00); dig(8); opk(2'b01);
        serve(2, 16'h0015, 1'b0, 1'b0, seen);
        checks++;
        if (!seen || cap_a !== 16'h0007 || cap_b !== 16'h0008 || cap_sub !== 1'b0) begin
            fails++; $display("FAIL chain_req1 seen=%0d a=%h b=%h sub=%b exp a=0007 b=0008 sub=0", seen, cap_a, cap_b, cap_sub);
        end
        checks++;
        if (disp_bcd !== 16'h0015 || busy !== 1'b0) begin
            fails++; $display("FAIL chain_mid got=%h busy=%b exp=0015 busy=0", disp_bcd, busy);
        end
        dig(2); eqk();
        serve(0, 16'h0013, 1'b0, 1'b0, seen);
        checks++;
        if (!seen || cap_a !== 16'h0015 || cap_b !== 16'h0002 || cap_sub !== 1'b1) begin
            fails++; $display("FAIL chain_req2 seen=%0d a=%h b=%h sub=%b exp a=0015 b=0002 sub=1", seen, cap_a, cap_b, cap_sub);
        end
        checks++;
        if (disp_bcd !== 16'h0013 || disp_neg !== 1'b0) begin
            fails++; $display("FAIL chain_result got=%h neg=%b exp=0013 neg=0", disp_bcd, disp_neg);
        end
    endtask

    task automatic test_timeout();
        int t0, s0, n;
        opk(2'b11);
        dig(1); opk(2'b00); dig(2);
        s0 = start_cnt;
        eqk();
        t0 = cyc;
        checks++;
        if (busy !== 1'b1 || alu_start !== 1'b1) begin
            fails++; $display("FAIL timeout_enter busy=%b start=%b exp busy=1 start=1", busy, alu_start);
        end
        dig(9); opk(2'b11); eqk();
        checks++;
        if (busy !== 1'b1 || disp_bcd !== 16'h0002 || disp_err !== 1'b0) begin
            fails++; $display("FAIL timeout_keys_ignored busy=%b disp=%h err=%b exp busy=1 disp=0002 err=0", busy, disp_bcd, disp_err);
        end
        n = 0;
        while (disp_err !== 1'b1 && n < TIMEOUT + 20) begin @(negedge clk); n++; end
        checks++;
        if (disp_err !== 1'b1 || cyc - t0 != TIMEOUT || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_error err=%b cycles=%0d busy=%b exp err=1 cycles=%0d busy=0",
                              disp_err, cyc - t0, busy, TIMEOUT);
        end
        checks++;
        if (start_cnt - s0 != 1) begin fails++; $display("FAIL timeout_starts got=%0d exp=1", start_cnt - s0); end
        opk(2'b11);
    endtask

    task automatic test_rst_in_exec();
        dig(4); opk(2'b00); dig(5); eqk();
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rst_exec_busy got=%b exp=1", busy); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; alu_done = 1'b1; alu_result = 16'h0009;
        @(negedge clk); alu_done = 1'b0; alu_result = '0;
        checks++;
        if ({alu_start, alu_sub, busy, disp_neg, disp_err} !== 5'b0 || {alu_a, alu_b, disp_bcd} !== 48'h0) begin
            fails++; $display("FAIL rst_exec_outputs flags=%b buses=%h exp all zero",
                              {alu_start, alu_sub, busy, disp_neg, disp_err}, {alu_a, alu_b, disp_bcd});
        end
        dig(6);
        checks++;
        if (disp_bcd !== 16'h0006) begin fails++; $display("FAIL rst_exec_entry got=%h exp=0006", disp_bcd); end
    endtask

    task automatic test_random();
        bit seen, e, o, n;
        int r, nv, ov, v, mag;
        opk(2'b11);
        model_reset();
        for (int k = 0; k < 300; k++) begin
            e = 0; o = 0; n = 0; nv = 0; ov = 0;
            r = $urandom_range(0, 99);
            if (m_mode == MERR && r < 30) begin o = 1; ov = 3; end
            else if (r < 50) begin n = 1; nv = $urandom_range(0, 9); end
            else if (r < 55) begin n = 1; nv = $urandom_range(10, 15); end
            else if (r < 72) begin o = 1; ov = $urandom_range(0, 1); end
            else if (r < 75) begin o = 1; ov = 2; end
            else if (r < 77) begin o = 1; ov = 3; end
            else if (r < 93) e = 1;
            else begin e = $urandom_range(0, 1); o = 1; n = 1; nv = $urandom_range(0, 15); ov = $urandom_range(0, 3); end
            press(e, o, n, 4'(nv), 2'(ov));
            model_key(e, o, n, nv, ov);
            if (m_mode == MEX) begin
                v = rsub ? ra - rb : ra + rb;
                mag = (v < 0) ? -v : v;
                serve($urandom_range(0, 3), int2bcd(mag % 10000), v < 0, mag > 9999, seen);
                checks++;
                if (!seen || cap_a !== int2bcd(ra) || cap_b !== int2bcd(rb) || cap_sub !== 1'(rsub)) begin
                    fails++; $display("FAIL rand_request k=%0d seen=%0d a=%h b=%h sub=%b exp a=%h b=%h sub=%0d",
                                      k, seen, cap_a, cap_b, cap_sub, int2bcd(ra), int2bcd(rb), rsub);
                end
                model_done(v);
            end else if ($urandom_range(0, 19) == 0) begin
                @(negedge clk); alu_done = 1'b1; alu_result = 16'h9999; alu_ovf = 1'b1;
                @(negedge clk); alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
            end
            checks++;
            if (disp_bcd !== (m_mode == MERR ? 16'h0 : int2bcd(m_mode == MB ? mb : (m_mode == MRES ? mres : ma)))
                || disp_neg !== 1'(m_mode == MRES && mneg != 0) || disp_err !== 1'(m_mode == MERR) || busy !== 1'b0) begin
                fails++; $display("FAIL rand_display k=%0d disp=%h neg=%b err=%b busy=%b exp mode=%0d a=%0d b=%0d res=%0d neg=%0d",
                                  k, disp_bcd, disp_neg, disp_err, busy, m_mode, ma, mb, mres, mneg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_neg();
        test_overflow();
        test_chain();
        test_timeout();
        test_rst_in_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
